// File: rtl/accum_8bit_stream_pkg.sv
// Shared types and helpers for the 8-bit sample accumulator.
package accum_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ACC,
      DONE
   } accum_state_t;

   localparam int DATA_W = 8;

   // Width needed to hold a count from 0 to n inclusive.
   function automatic int cnt_w(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/accum_8bit_stream_if.sv
// Sample-in / frame-total-out valid/ready bus for accum_8bit_stream.
// The slave modport is the accumulator side; master is the producer/consumer side.
interface accum_8bit_stream_if #(
   parameter int ACC_W = 16
);

   logic [7:0]       in_data;
   logic             in_valid;
   logic             in_ready;
   logic [ACC_W-1:0] out_sum;
   logic             out_ovf;
   logic             out_valid;
   logic             out_ready;

   modport slave (
      input  in_data,
      input  in_valid,
      output in_ready,
      output out_sum,
      output out_ovf,
      output out_valid,
      input  out_ready
   );

   modport master (
      output in_data,
      output in_valid,
      input  in_ready,
      input  out_sum,
      input  out_ovf,
      input  out_valid,
      output out_ready
   );

endinterface

// File: rtl/accum_8bit_stream_adder.sv
// Plain 8-bit ripple adder with carry in/out; sums the low accumulator byte.
module adder_8bit (
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  logic       cin,
   output logic [7:0] sum,
   output logic       cout
);

   // Nine-bit add so the carry-out falls out as the top bit.
   always_comb begin
      {cout, sum} = {1'b0, a} + {1'b0, b} + {8'b0, cin};
   end

endmodule

// File: rtl/accum_8bit_stream.sv
// Frame accumulator: sums NUM_SAMPLES 8-bit samples into an ACC_W-bit total and
// offers it downstream over valid/ready.
// Optional build macro ACCUM_SATURATE_EN: clamp the total to all-ones on overflow
// instead of wrapping.
module accum_8bit_stream
   import accum_pkg::*;
#(
   parameter int ACC_W       = 16,
   parameter int NUM_SAMPLES = 4
) (
   input logic               clk,
   input logic               rst,
   accum_8bit_stream_if.slave bus
);

   localparam int               HI_W = ACC_W - DATA_W;
   localparam int               CW   = cnt_w(NUM_SAMPLES);
   localparam logic [CW-1:0]    LAST = CW'(NUM_SAMPLES);

   accum_state_t     state;
   logic [ACC_W-1:0] acc;
   logic [CW-1:0]    cnt;
   logic             ovf;
   logic             in_rdy_q;
   logic             out_vld_q;

   logic [DATA_W-1:0] lo_sum;
   logic              lo_cout;
   logic [HI_W-1:0]   hi_nxt;
   logic              wrap;
   logic              accept;
   logic [ACC_W-1:0]  acc_nxt;
   logic [CW-1:0]     cnt_inc;

   adder_8bit u_lo_add (
      .a    (acc[DATA_W-1:0]),
      .b    (bus.in_data),
      .cin  (1'b0),
      .sum  (lo_sum),
      .cout (lo_cout)
   );

   // Upper-bit increment, overflow detect and next accumulator value.
   always_comb begin
      hi_nxt  = acc[ACC_W-1:DATA_W] + HI_W'(lo_cout);
      wrap    = lo_cout & (&acc[ACC_W-1:DATA_W]);
      accept  = bus.in_valid & in_rdy_q;
      cnt_inc = cnt + CW'(1);
`ifdef ACCUM_SATURATE_EN
      // Once clamped, the frame stays pinned at all-ones.
      acc_nxt = (wrap | ovf) ? '1 : {hi_nxt, lo_sum};
`else
      acc_nxt = {hi_nxt, lo_sum};
`endif
   end

   // Frame FSM with registered handshake outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         acc       <= '0;
         cnt       <= '0;
         ovf       <= 1'b0;
         in_rdy_q  <= 1'b0;
         out_vld_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               in_rdy_q <= 1'b1;
               if (accept) begin
                  acc <= acc_nxt;
                  ovf <= ovf | wrap;
                  cnt <= CW'(1);
                  if (NUM_SAMPLES == 1) begin
                     state     <= DONE;
                     in_rdy_q  <= 1'b0;
                     out_vld_q <= 1'b1;
                  end else begin
                     state <= ACC;
                  end
               end
            end
            ACC: begin
               if (accept) begin
                  acc <= acc_nxt;
                  ovf <= ovf | wrap;
                  cnt <= cnt_inc;
                  if (cnt_inc == LAST) begin
                     state     <= DONE;
                     in_rdy_q  <= 1'b0;
                     out_vld_q <= 1'b1;
                  end
               end
            end
            DONE: begin
               if (out_vld_q && bus.out_ready) begin
                  state     <= IDLE;
                  acc       <= '0;
                  cnt       <= '0;
                  ovf       <= 1'b0;
                  in_rdy_q  <= 1'b1;
                  out_vld_q <= 1'b0;
               end
            end
            default: begin
               state     <= IDLE;
               in_rdy_q  <= 1'b0;
               out_vld_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.in_ready  = in_rdy_q;
   assign bus.out_sum   = acc;
   assign bus.out_ovf   = ovf;
   assign bus.out_valid = out_vld_q;

endmodule

// File: tb/tb_accum_8bit_stream.sv
// Bench for accum_8bit_stream: table of 4-sample frames through a scoreboard,
// plus hand-written backpressure, async-reset and narrow-accumulator sequences.
module tb_accum_8bit_stream;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   accum_8bit_stream_if #(.ACC_W(16)) if16 ();
   accum_8bit_stream_if #(.ACC_W(9))  if9  ();

   accum_8bit_stream #(.ACC_W(16), .NUM_SAMPLES(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (if16.slave)
   );

   accum_8bit_stream #(.ACC_W(9), .NUM_SAMPLES(4)) dut9 (
      .clk (clk),
      .rst (rst),
      .bus (if9.slave)
   );

   typedef struct packed {
      logic [3:0][7:0] s;
      logic [15:0]     sum;
      logic            ovf;
   } vec_t;

   typedef struct packed {
      logic [15:0] sum;
      logic        ovf;
   } exp_t;

   int   checks = 0;
   int   fails  = 0;
   exp_t sbq[$];
   vec_t vecs[5];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard: pop one expected total per output handshake.
   always @(negedge clk) begin
      if (!rst && if16.out_valid && if16.out_ready) begin
         if (sbq.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL sb_unexpected: got sum 0x%0h, expected no output", if16.out_sum);
         end else begin
            exp_t e;
            e = sbq.pop_front();
            check("sb_sum", 32'(if16.out_sum), 32'(e.sum));
            check("sb_ovf", 32'(if16.out_ovf), 32'(e.ovf));
         end
      end
   end

   task automatic send_frame(input logic [3:0][7:0] s);
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         if16.in_valid = 1'b1;
         if16.in_data  = s[i];
         if (i > 0) begin
            @(negedge clk);
            check("early_valid", 32'(if16.out_valid), 32'd0);
         end
      end
      @(posedge clk); #1;
      if16.in_valid = 1'b0;
      @(negedge clk);
      check("lat_valid", 32'(if16.out_valid), 32'd1);
      check("done_inrdy", 32'(if16.in_ready), 32'd0);
   endtask

   initial begin
      int total9;
      logic [8:0] exp9;

      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int          total9;
      logic [8:0]  exp9_sum;
      logic        exp9_ovf;

      vecs[0] = '{s: {8'd40, 8'd30, 8'd20, 8'd10},     sum: 16'd100,   ovf: 1'b0};
      vecs[1] = '{s: {8'hFF, 8'hFF, 8'hFF, 8'hFF},     sum: 16'h03FC,  ovf: 1'b0};
      vecs[2] = '{s: {8'h00, 8'h00, 8'h00, 8'h00},     sum: 16'h0000,  ovf: 1'b0};
      vecs[3] = '{s: {8'h80, 8'h80, 8'h80, 8'h80},     sum: 16'h0200,  ovf: 1'b0};
      vecs[4] = '{s: {8'd4, 8'd3, 8'd2, 8'd1},         sum: 16'd10,    ovf: 1'b0};

      if16.in_data   = '0;
      if16.in_valid  = 1'b0;
      if16.out_ready = 1'b1;
      if9.in_data    = '0;
      if9.in_valid   = 1'b0;
      if9.out_ready  = 1'b1;

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_inrdy", 32'(if16.in_ready), 32'd0);
      check("rst_valid", 32'(if16.out_valid), 32'd0);
      check("rst_sum", 32'(if16.out_sum), 32'd0);
      check("rst_ovf", 32'(if16.out_ovf), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("rdy_before_edge", 32'(if16.in_ready), 32'd0);
      @(negedge clk);
      check("rdy_after_edge", 32'(if16.in_ready), 32'd1);

      // Table-driven frames, downstream always ready
      for (int v = 0; v < 5; v++) begin
         sbq.push_back('{sum: vecs[v].sum, ovf: vecs[v].ovf});
         send_frame(vecs[v].s);
         @(negedge clk);
         check("idle_valid", 32'(if16.out_valid), 32'd0);
         check("idle_inrdy", 32'(if16.in_ready), 32'd1);
      end

      // Backpressure in DONE with extra input offered
      if16.out_ready = 1'b0;
      sbq.push_back('{sum: 16'd26, ovf: 1'b0});
      send_frame({8'd8, 8'd7, 8'd6, 8'd5});
      @(posedge clk); #1;
      if16.in_valid = 1'b1;
      if16.in_data  = 8'd99;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("bp_valid", 32'(if16.out_valid), 32'd1);
         check("bp_inrdy", 32'(if16.in_ready), 32'd0);
         check("bp_sum", 32'(if16.out_sum), 32'd26);
      end
      @(posedge clk); #1;
      if16.in_valid  = 1'b0;
      if16.out_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("bp_one_xfer", 32'(if16.out_valid), 32'd0);
      check("bp_cleared", 32'(if16.out_sum), 32'd0);
      sbq.push_back('{sum: 16'd4, ovf: 1'b0});
      send_frame({8'd1, 8'd1, 8'd1, 8'd1});
      @(negedge clk);

      // Asynchronous reset mid-frame
      @(posedge clk); #1;
      if16.in_valid = 1'b1;
      if16.in_data  = 8'd50;
      @(posedge clk); #1;
      if16.in_data  = 8'd60;
      @(posedge clk); #1;
      if16.in_valid = 1'b0;
      #1;
      check("partial_sum", 32'(if16.out_sum), 32'd110);
      #1;
      rst = 1'b1;
      #1;
      check("arst_sum", 32'(if16.out_sum), 32'd0);
      check("arst_inrdy", 32'(if16.in_ready), 32'd0);
      check("arst_valid", 32'(if16.out_valid), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      check("arst_rdy_back", 32'(if16.in_ready), 32'd1);
      sbq.push_back('{sum: 16'd10, ovf: 1'b0});
      send_frame({8'd4, 8'd3, 8'd2, 8'd1});
      @(negedge clk);

      // Narrow accumulator: four 0xFF samples overflow a 9-bit total
      total9 = 4 * 255;
`ifdef ACCUM_SATURATE_EN
      exp9_sum = (total9 > 511) ? 9'h1FF : 9'(total9);
`else
      exp9_sum = 9'(total9 % 512);
`endif
      exp9_ovf = (total9 > 511);
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         if9.in_valid = 1'b1;
         if9.in_data  = 8'hFF;
      end
      @(posedge clk); #1;
      if9.in_valid = 1'b0;
      @(negedge clk);
      check("w9_valid", 32'(if9.out_valid), 32'd1);
      check("w9_sum", 32'(if9.out_sum), 32'(exp9_sum));
      check("w9_ovf", 32'(if9.out_ovf), 32'(exp9_ovf));
      @(negedge clk);
      check("w9_clear_ovf", 32'(if9.out_ovf), 32'd0);
      check("w9_clear_valid", 32'(if9.out_valid), 32'd0);

      repeat (2) @(negedge clk);
      check("sb_drained", 32'(sbq.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
